pwm_deadtime: RTL and testbench
===============================

PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 Parameter DT_W, default 6, SHALL set the width of the dead-time value in bits.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 PWM_sig  input  1  SHALL be the raw PWM from the 11-bit PWM generator, synchronous to clk.
REQ-005 en  input  1  SHALL enable the bridge leg; low forces both gates off.
REQ-006 dead_time  input  DT_W  SHALL give the non-overlap interval in clk cycles; sampled when a dead interval starts.
REQ-007 ovr_I  input  1  SHALL signal an over-current fault; active high.
REQ-008 clr_flt  input  1  SHALL be a fault-clear request; active high.
REQ-009 high_out  output  1  SHALL drive the high-side gate; active high.
REQ-010 low_out  output  1  SHALL drive the low-side gate; active high.
REQ-011 fault_latched  output  1  SHALL be high while the block is in fault.

Function
REQ-012 PWM_sig SHALL be registered once into pwm_q; all decisions SHALL use pwm_q.
REQ-013 The FSM SHALL have exactly five states: OFF, DEAD, HI, LO, FLT.
REQ-014 high_out SHALL be 1 only in HI; low_out SHALL be 1 only in LO; fault_latched SHALL be 1 only in FLT. All three SHALL come glitch-free from flops.
REQ-015 high_out and low_out SHALL never be 1 in the same cycle.
REQ-016 Priority per cycle SHALL be: ovr_I, then en low, then normal transitions.
REQ-017 With ovr_I = 1 in any state, the next state SHALL be FLT.
REQ-018 With en = 0 and ovr_I = 0 in any state other than FLT, the next state SHALL be OFF.
REQ-019 OFF -> DEAD when en = 1; dead counter loads dead_time.
REQ-020 In DEAD, if pwm_q differs from its prior-cycle value, the counter SHALL reload dead_time and the state SHALL stay DEAD.
REQ-021 In DEAD, if the counter is <= 1, the next state SHALL be HI when pwm_q = 1, else LO; otherwise the counter SHALL decrement.
REQ-022 Both gates SHALL be low for exactly max(dead_time,1) cycles per dead interval; dead_time = 0 SHALL behave as 1.
REQ-023 HI -> DEAD when pwm_q = 0; LO -> DEAD when pwm_q = 1; the counter loads dead_time on entry.
REQ-024 Latency: a PWM_sig change sampled at edge k SHALL drop the active gate at edge k+1. The opposite gate SHALL rise at edge k+1+max(dead_time,1).
REQ-025 FLT -> OFF SHALL occur only when clr_flt = 1 and ovr_I = 0 in the same cycle. clr_flt while ovr_I = 1 SHALL be ignored.
REQ-026 A change of dead_time SHALL affect only dead intervals that start afterwards.
REQ-027 The dead counter SHALL be DT_W bits wide and SHALL never wrap below 0.

Reset
REQ-028 While rst_n = 0, the block SHALL be in OFF with pwm_q = 0, counter = 0, and high_out = low_out = fault_latched = 0.
REQ-029 Asserting rst_n mid-operation, including in HI, LO or FLT, SHALL force REQ-028 values immediately, without waiting for clk.
REQ-030 After reset release, both gates SHALL remain low until the path OFF -> DEAD completes.

Verification
REQ-031 Reset release, en = 1, dead_time = 5, PWM_sig = 1 -> high_out rises 6 cycles after en is sampled; low_out stays 0.
REQ-032 In HI with dead_time = 5, PWM_sig falls at edge k -> high_out = 0 at k+1; low_out = 1 at k+6; gates never overlap.
REQ-033 In DEAD with dead_time = 8, PWM_sig toggles twice 3 cycles apart -> both gates stay low until 8 cycles after the last pwm_q change.
REQ-034 In LO, ovr_I pulses for 1 cycle -> both gates 0 and fault_latched = 1 next edge. clr_flt with ovr_I = 1 -> remains FLT. clr_flt with ovr_I = 0 -> OFF, then DEAD, then a gate per pwm_q.
REQ-035 dead_time = 0, 11-bit PWM with duty 0x400 -> dead gaps are 1 cycle each and high/low never both 1 across 3 PWM periods. en dropped mid-HI -> OFF next edge.
REQ-036 rst_n asserted asynchronously mid-HI -> high_out = 0 before the next clk edge, and the REQ-028 values hold.

Source files
------------

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - half-bridge gate driver with programmable dead time and latched over-current fault
module pwm_deadtime #(
    parameter int DT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PWM_sig,
    input  logic            en,
    input  logic [DT_W-1:0] dead_time,
    input  logic            ovr_I,
    input  logic            clr_flt,
    output logic            high_out,
    output logic            low_out,
    output logic            fault_latched
);

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        DEAD = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        FLT  = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic            pwm_q, pwm_prev;
    logic [DT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= OFF;
            pwm_q         <= 1'b0;
            pwm_prev      <= 1'b0;
            cnt           <= '0;
            high_out      <= 1'b0;
            low_out       <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_nxt;
            pwm_q         <= PWM_sig;
            pwm_prev      <= pwm_q;
            cnt           <= cnt_nxt;
            // Gate outputs are decoded from the next state so they are plain flops aligned with state.
            high_out      <= (state_nxt == HI);
            low_out       <= (state_nxt == LO);
            fault_latched <= (state_nxt == FLT);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ovr_I) begin
            state_nxt = FLT;
        end else if (!en && state != FLT) begin
            state_nxt = OFF;
        end else begin
            case (state)
                OFF: begin
                    state_nxt = DEAD;
                    cnt_nxt   = dead_time;
                end
                DEAD: begin
                    // A PWM edge inside the dead window restarts the full interval.
                    if (pwm_q != pwm_prev) begin
                        cnt_nxt = dead_time;
                    end else if (cnt <= DT_W'(1)) begin
                        state_nxt = pwm_q ? HI : LO;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                HI: begin
                    if (!pwm_q) begin
                        state_nxt = DEAD;
                        cnt_nxt   = dead_time;
                    end
                end
                LO: begin
                    if (pwm_q) begin
                        state_nxt = DEAD;
                        cnt_nxt   = dead_time;
                    end
                end
                FLT: begin
                    if (clr_flt) begin
                        state_nxt = OFF;
                    end
                end
                default: begin
                    state_nxt = OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb/tb_pwm_deadtime.sv - directed self-checking bench for pwm_deadtime
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       PWM_sig;
    logic       en;
    logic [5:0] dead_time;
    logic       ovr_I;
    logic       clr_flt;
    logic       high_out;
    logic       low_out;
    logic       fault_latched;

    int n_assert = 0;
    int n_fail   = 0;

    pwm_deadtime #(.DT_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PWM_sig       (PWM_sig),
        .en            (en),
        .dead_time     (dead_time),
        .ovr_I         (ovr_I),
        .clr_flt       (clr_flt),
        .high_out      (high_out),
        .low_out       (low_out),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic h, input logic l, input logic f);
        n_assert++;
        assert ({high_out, low_out, fault_latched} === {h, l, f})
        else begin
            n_fail++;
            $error("FAIL %s: observed hi/lo/flt=%b%b%b expected %b%b%b",
                   tag, high_out, low_out, fault_latched, h, l, f);
        end
    endtask

    initial begin
        logic [10:0] pc;
        int gap;
        int gaps;

        rst_n = 1'b0; PWM_sig = 1'b0; en = 1'b0; dead_time = 6'd5;
        ovr_I = 1'b0; clr_flt = 1'b0;
        tick();
        chk("reset", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_en0", 0, 0, 0);

        // Startup: en and PWM high together, high side after 6 edges.
        en = 1'b1; PWM_sig = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("startup_dead", 0, 0, 0);
        end
        tick();
        chk("startup_hi", 1, 0, 0);

        // HI -> LO with dead_time 5.
        PWM_sig = 1'b0;
        tick();
        chk("hi_hold_k", 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hi_lo_dead", 0, 0, 0);
        end
        tick();
        chk("lo_rise", 0, 1, 0);

        // Two PWM edges inside an 8-cycle dead window; late dead_time change ignored.
        dead_time = 6'd8; PWM_sig = 1'b1;
        tick();
        chk("lo_hold_k", 0, 1, 0);
        tick();
        chk("dead8_entry", 0, 0, 0);
        PWM_sig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dead8_toggle1", 0, 0, 0);
        end
        PWM_sig = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("dead8_toggle2", 0, 0, 0);
            if (i == 1) dead_time = 6'd3;
        end
        tick();
        chk("dead8_hi", 1, 0, 0);

        // HI -> LO with dead_time 3, then over-current fault from LO.
        PWM_sig = 1'b0;
        tick();
        chk("hi_hold_k2", 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dead3", 0, 0, 0);
        end
        tick();
        chk("lo_dt3", 0, 1, 0);
        ovr_I = 1'b1;
        tick();
        chk("fault_enter", 0, 0, 1);
        ovr_I = 1'b0;
        tick();
        chk("fault_hold", 0, 0, 1);
        ovr_I = 1'b1; clr_flt = 1'b1;
        tick();
        chk("clr_ignored", 0, 0, 1);
        ovr_I = 1'b0;
        tick();
        chk("clr_to_off", 0, 0, 0);
        clr_flt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("refault_dead", 0, 0, 0);
        end
        tick();
        chk("refault_lo", 0, 1, 0);

        // Three 11-bit PWM periods, duty 0x400, dead_time 0.
        dead_time = 6'd0;
        pc = 11'd0; gap = 0; gaps = 0;
        for (int i = 0; i < 3 * 2048; i++) begin
            PWM_sig = (pc < 11'h400);
            pc = pc + 11'd1;
            tick();
            n_assert++;
            assert (!(high_out && low_out))
            else begin
                n_fail++;
                $error("FAIL overlap: observed hi=%b lo=%b expected not both 1", high_out, low_out);
            end
            if (high_out || low_out) begin
                if (gap > 0) begin
                    n_assert++;
                    assert (gap == 1)
                    else begin
                        n_fail++;
                        $error("FAIL gap_len: observed %0d expected 1", gap);
                    end
                    gaps++;
                end
                gap = 0;
            end else begin
                gap++;
            end
        end
        n_assert++;
        assert (gaps == 6)
        else begin
            n_fail++;
            $error("FAIL gap_count: observed %0d expected 6", gaps);
        end

        // en dropped mid-HI.
        PWM_sig = 1'b1;
        tick();
        chk("dt0_lo_hold", 0, 1, 0);
        tick();
        chk("dt0_dead", 0, 0, 0);
        tick();
        chk("dt0_hi", 1, 0, 0);
        en = 1'b0;
        tick();
        chk("en_drop", 0, 0, 0);

        // Asynchronous reset mid-HI.
        en = 1'b1;
        tick();
        chk("reenter_dead", 0, 0, 0);
        tick();
        chk("reenter_hi", 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 0, 0, 0);
        tick();
        chk("reset_hold", 0, 0, 0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
